vram_write_arbiter: RTL and testbench
=====================================

// Module: vram_write_arbiter
// PURPOSE
//  Shares the single write port of the 400x240x3 video memory between two requesters:
//  - the CPU's VGA-opcode pixel writes;
//  - a hardware rectangle-fill engine that rasterises solid-colour boxes.
//  Sits between MiniAlu's VGA write path and the VideoMemory write port.
//  The CPU has absolute priority; the fill engine uses idle cycles only.
// PARAMETERS
//  FB_WIDTH   400  framebuffer columns (pixels)
//  FB_HEIGHT  240  framebuffer rows
//  ADDR_W     19   video memory address width
//  COLOR_W    3    pixel colour width {R,G,B}
// PORTS
//  Clock       in   1        system clock, all logic on posedge
//  Reset       in   1        asynchronous, active-low (0 = reset)
//  iCpuWrite   in   1        CPU pixel write strobe, one pixel per cycle high
//  iCpuAddr    in   ADDR_W   CPU linear pixel address (400*row+col)
//  iCpuColor   in   COLOR_W  CPU pixel colour
//  iFillStart  in   1        start rectangle fill (sampled only in IDLE)
//  iFillAbort  in   1        abandon fill in progress
//  iFillX0     in   9        rectangle left column
//  iFillY0     in   8        rectangle top row
//  iFillW      in   9        rectangle width in pixels
//  iFillH      in   8        rectangle height in pixels
//  iFillColor  in   COLOR_W  fill colour
//  oWriteEnable out 1        video memory write enable
//  oWriteAddr  out  ADDR_W   video memory write address
//  oWriteColor out  COLOR_W  video memory write data
//  oFillBusy   out  1        fill engine in FILL state
//  oFillDone   out  1        one-cycle pulse, fill completed normally
//  oFillError  out  1        one-cycle pulse, fill request rejected
// BEHAVIOUR
//  Reset values: all outputs 0; FSM = IDLE; all fill counters 0.
//  Output registers: all outputs are registered.
//  CPU path latency: iCpuWrite high at edge n -> oWriteEnable=1 with that addr/colour during cycle n+1.
//  The CPU is never stalled.
//  FSM states: IDLE, FILL, DONE.
//  IDLE + iFillStart:
//   - Reject when W==0, H==0, X0+W>FB_WIDTH or Y0+H>FB_HEIGHT.
//   - On reject: oFillError=1 for one cycle, stay in IDLE, no writes.
//   - Otherwise: latch X0/Y0/W/H/colour, set base=FB_WIDTH*Y0+X0, go to FILL, oFillBusy=1.
//  Address generation: strictly incremental, no multiplier.
//   - Raster order: x from X0 to X0+W-1, then next row.
//   - Row base += FB_WIDTH on each row wrap.
//   - Pixel address = row base + x offset.
//  FILL, each edge:
//   - iCpuWrite=0: present the next fill pixel on the write port, advance the counters.
//   - iCpuWrite=1: present the CPU write, hold the fill counters.
//  FILL -> DONE: when the last pixel (x=X0+W-1, y=Y0+H-1) is issued.
//  DONE -> IDLE after one cycle; oFillDone=1 and oFillBusy=0 during DONE.
//  Uncontended timing: start sampled at edge k ->
//   - fill writes occupy cycles k+2 .. k+1+W*H;
//   - oFillDone pulses in cycle k+2+W*H.
//  iFillAbort (any state) -> IDLE next edge:
//   - no further fill writes, no oFillDone;
//   - a CPU write in the same cycle is still issued.
//  iFillStart outside IDLE: ignored, no error pulse.
//  iFillStart and iFillAbort together in IDLE: abort wins, start ignored.
//  Reset asserted mid-fill: the fill is discarded immediately; outputs return to reset values.
//  Input changes while busy: fill inputs are ignored after latching.
// STRUCTURE
//  Shared constants in Defintions.v: FB_WIDTH/FB_HEIGHT defaults, COLOR_BLACK.
//  FSM state encodings: localparams in this file.
//  Sub-module fill_raster_counter:
//   - x/y counters, row-base accumulator, linear address;
//   - hold/advance input; last-pixel flag.
//  This module holds the FSM, validation, the priority mux and the output registers.
// TESTING
//  1. Reset low, then high, no requests -> all outputs 0; no writes for 10 cycles.
//  2. Fill X0=0,Y0=0,W=3,H=2, colour 3'b100, no CPU traffic:
//     - addresses 0,1,2,400,401,402 in consecutive cycles, colour 3'b100;
//     - oFillDone pulses once, in the cycle after the last write.
//  3. Same fill with iCpuWrite addr=1000 colour 3'b010 held 2 cycles mid-fill:
//     - two CPU writes to 1000 are inserted;
//     - the fill resumes at the held pixel; all 6 fill addresses appear;
//     - done arrives 2 cycles late.
//  4. Fill X0=398,W=3 (398+3>400) -> oFillError pulse, no writes, oFillBusy stays 0.
//     W=0 gives the same result.
//  5. Fill X0=399,Y0=239,W=1,H=1 -> single write at address 95999, then oFillDone.
//  6. Abort and reset mid-fill (10x10 fill):
//     - iFillAbort after 4 writes -> 4 writes total, no oFillDone; a new start then succeeds;
//     - Reset low mid-fill -> immediate zero outputs, state IDLE.

Source files
------------

// File: rtl/vram_write_arbiter_pkg.sv
// Shared framebuffer geometry, colour constants and fill FSM state type for the VRAM
// write arbiter.
package vram_write_arbiter_pkg;

    localparam int unsigned FB_WIDTH_DEF  = 400;
    localparam int unsigned FB_HEIGHT_DEF = 240;
    localparam int unsigned ADDR_W_DEF    = 19;
    localparam int unsigned COLOR_W_DEF   = 3;

    localparam logic [2:0] COLOR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fill_state_e;

    // A rectangle is accepted only if it is non-empty and lies fully inside the framebuffer.
    function automatic logic rect_fits(
        input logic [8:0]  x0,
        input logic [8:0]  w,
        input logic [7:0]  y0,
        input logic [7:0]  h,
        input int unsigned fb_w,
        input int unsigned fb_h
    );
        return (w != 9'd0) && (h != 8'd0) &&
               ((32'(x0) + 32'(w)) <= fb_w) &&
               ((32'(y0) + 32'(h)) <= fb_h);
    endfunction

endpackage

// File: rtl/vram_write_arbiter_fill_raster_counter.sv
// Raster-order pixel counter for the fill engine: x/y offsets, row-base accumulator and
// linear address, built incrementally without a multiplier.
module vram_write_arbiter_fill_raster_counter
    import vram_write_arbiter_pkg::*;
#(
    parameter int unsigned FB_WIDTH = FB_WIDTH_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iLoad,
    input  logic              iAdvance,
    input  logic [ADDR_W-1:0] iBase,
    input  logic [8:0]        iW,
    input  logic [7:0]        iH,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oLast
);

    logic [8:0]        x_q, x_d, w_q, w_d;
    logic [7:0]        y_q, y_d, h_q, h_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              x_end, y_end;

    assign x_end = (x_q == (w_q - 9'd1));
    assign y_end = (y_q == (h_q - 8'd1));

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        row_base_d = row_base_q;
        if (iLoad) begin
            x_d        = 9'd0;
            y_d        = 8'd0;
            w_d        = iW;
            h_d        = iH;
            row_base_d = iBase;
        end else if (iAdvance) begin
            if (x_end) begin
                x_d        = 9'd0;
                y_d        = y_q + 8'd1;
                row_base_d = row_base_q + ADDR_W'(FB_WIDTH);
            end else begin
                x_d = x_q + 9'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            row_base_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            row_base_q <= row_base_d;
        end
    end

    assign oAddr = row_base_q + ADDR_W'(x_q);
    assign oLast = x_end && y_end;

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates the video memory write port between CPU pixel writes (absolute priority)
// and the rectangle-fill engine, which only uses idle cycles.
module vram_write_arbiter
    import vram_write_arbiter_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned COLOR_W   = COLOR_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iCpuWrite,
    input  logic [ADDR_W-1:0]  iCpuAddr,
    input  logic [COLOR_W-1:0] iCpuColor,
    input  logic               iFillStart,
    input  logic               iFillAbort,
    input  logic [8:0]         iFillX0,
    input  logic [7:0]         iFillY0,
    input  logic [8:0]         iFillW,
    input  logic [7:0]         iFillH,
    input  logic [COLOR_W-1:0] iFillColor,
    output logic               oWriteEnable,
    output logic [ADDR_W-1:0]  oWriteAddr,
    output logic [COLOR_W-1:0] oWriteColor,
    output logic               oFillBusy,
    output logic               oFillDone,
    output logic               oFillError
);

    fill_state_e        state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [COLOR_W-1:0] fill_color_q, fill_color_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               cnt_load, cnt_advance, cnt_last;
    logic [ADDR_W-1:0]  cnt_addr, start_base;

    assign start_base = ADDR_W'(FB_WIDTH) * ADDR_W'(iFillY0) + ADDR_W'(iFillX0);

    vram_write_arbiter_fill_raster_counter #(
        .FB_WIDTH (FB_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_raster (
        .Clock    (Clock),
        .Reset    (Reset),
        .iLoad    (cnt_load),
        .iAdvance (cnt_advance),
        .iBase    (start_base),
        .iW       (iFillW),
        .iH       (iFillH),
        .oAddr    (cnt_addr),
        .oLast    (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        fill_color_d = fill_color_q;
        we_d         = 1'b0;
        addr_d       = '0;
        color_d      = COLOR_W'(COLOR_BLACK);
        done_d       = 1'b0;
        error_d      = 1'b0;
        cnt_load     = 1'b0;
        cnt_advance  = 1'b0;

        // The CPU is never stalled, whatever the fill engine is doing.
        if (iCpuWrite) begin
            we_d    = 1'b1;
            addr_d  = iCpuAddr;
            color_d = iCpuColor;
        end

        unique case (state_q)
            StIdle: begin
                if (!iFillAbort && iFillStart) begin
                    if (rect_fits(iFillX0, iFillW, iFillY0, iFillH, FB_WIDTH, FB_HEIGHT)) begin
                        cnt_load     = 1'b1;
                        fill_color_d = iFillColor;
                        state_d      = StFill;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StFill: begin
                if (iFillAbort) begin
                    state_d = StIdle;
                end else if (!iCpuWrite) begin
                    we_d        = 1'b1;
                    addr_d      = cnt_addr;
                    color_d     = fill_color_q;
                    cnt_advance = 1'b1;
                    if (cnt_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = !iFillAbort;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StFill);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= StIdle;
            fill_color_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            color_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_color_q <= fill_color_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            color_q      <= color_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign oWriteEnable = we_q;
    assign oWriteAddr   = addr_q;
    assign oWriteColor  = color_q;
    assign oFillBusy    = busy_q;
    assign oFillDone    = done_q;
    assign oFillError   = error_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: CPU priority, raster fill order, rejects,
// abort and asynchronous reset behaviour.
module tb_vram_write_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iCpuWrite;
    logic [18:0] iCpuAddr;
    logic [2:0]  iCpuColor;
    logic        iFillStart;
    logic        iFillAbort;
    logic [8:0]  iFillX0;
    logic [7:0]  iFillY0;
    logic [8:0]  iFillW;
    logic [7:0]  iFillH;
    logic [2:0]  iFillColor;
    logic        oWriteEnable;
    logic [18:0] oWriteAddr;
    logic [2:0]  oWriteColor;
    logic        oFillBusy;
    logic        oFillDone;
    logic        oFillError;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    vram_write_arbiter dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iCpuWrite    (iCpuWrite),
        .iCpuAddr     (iCpuAddr),
        .iCpuColor    (iCpuColor),
        .iFillStart   (iFillStart),
        .iFillAbort   (iFillAbort),
        .iFillX0      (iFillX0),
        .iFillY0      (iFillY0),
        .iFillW       (iFillW),
        .iFillH       (iFillH),
        .iFillColor   (iFillColor),
        .oWriteEnable (oWriteEnable),
        .oWriteAddr   (oWriteAddr),
        .oWriteColor  (oWriteColor),
        .oFillBusy    (oFillBusy),
        .oFillDone    (oFillDone),
        .oFillError   (oFillError)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_port(input string tag, input logic we, input logic [18:0] addr,
                               input logic [2:0] col);
        chk({tag, ".we"}, 32'(oWriteEnable), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(oWriteAddr), 32'(addr));
            chk({tag, ".color"}, 32'(oWriteColor), 32'(col));
        end
    endtask

    task automatic expect_flags(input string tag, input logic busy, input logic done,
                                input logic err);
        chk({tag, ".busy"}, 32'(oFillBusy), 32'(busy));
        chk({tag, ".done"}, 32'(oFillDone), 32'(done));
        chk({tag, ".error"}, 32'(oFillError), 32'(err));
    endtask

    task automatic clear_inputs();
        iCpuWrite  = 1'b0;
        iCpuAddr   = '0;
        iCpuColor  = '0;
        iFillStart = 1'b0;
        iFillAbort = 1'b0;
        iFillX0    = '0;
        iFillY0    = '0;
        iFillW     = '0;
        iFillH     = '0;
        iFillColor = '0;
    endtask

    task automatic fill(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] w,
                        input logic [7:0] h, input logic [2:0] col);
        iFillX0    = x0;
        iFillY0    = y0;
        iFillW     = w;
        iFillH     = h;
        iFillColor = col;
        iFillStart = 1'b1;
    endtask

    logic [18:0] seq_addr[8];
    logic [2:0]  seq_col[8];
    logic [8:0]  bad_x0[4];
    logic [7:0]  bad_y0[4];
    logic [8:0]  bad_w[4];
    logic [7:0]  bad_h[4];

    initial begin
        clear_inputs();
        Reset = 1'b0;

        // 1. reset, then idle
        repeat (3) @(posedge Clock);
        #1;
        expect_port("rst", 1'b0, 19'd0, 3'd0);
        chk("rst.addr", 32'(oWriteAddr), 32'd0);
        chk("rst.color", 32'(oWriteColor), 32'd0);
        expect_flags("rst", 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_port("idle", 1'b0, 19'd0, 3'd0);
            expect_flags("idle", 1'b0, 1'b0, 1'b0);
        end

        // 2. 3x2 fill at origin, no CPU traffic; a mid-fill start with W=0 is ignored
        seq_addr = '{19'd0, 19'd1, 19'd2, 19'd400, 19'd401, 19'd402, 19'd0, 19'd0};
        fill(9'd0, 8'd0, 9'd3, 8'd2, 3'b100);
        tick();
        iFillStart = 1'b0;
        expect_flags("f2.start", 1'b1, 1'b0, 1'b0);
        expect_port("f2.start", 1'b0, 19'd0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_port("f2.px", 1'b1, seq_addr[i], 3'b100);
            expect_flags("f2.px", (i < 5), 1'b0, 1'b0);
            if (i == 1) begin
                iFillStart = 1'b1;
                iFillW     = 9'd0;
                iFillColor = 3'b111;
            end
            if (i == 2) iFillStart = 1'b0;
        end
        tick();
        expect_port("f2.done", 1'b0, 19'd0, 3'd0);
        expect_flags("f2.done", 1'b0, 1'b1, 1'b0);
        tick();
        expect_flags("f2.after", 1'b0, 1'b0, 1'b0);

        // 3. same fill with two CPU writes inserted after the second pixel
        seq_addr = '{19'd0, 19'd1, 19'd1000, 19'd1000, 19'd2, 19'd400, 19'd401, 19'd402};
        seq_col  = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
        fill(9'd0, 8'd0, 9'd3, 8'd2, 3'b100);
        tick();
        iFillStart = 1'b0;
        expect_flags("f3.start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_port("f3.px", 1'b1, seq_addr[i], seq_col[i]);
            expect_flags("f3.px", (i < 7), 1'b0, 1'b0);
            if (i == 1) begin
                iCpuWrite = 1'b1;
                iCpuAddr  = 19'd1000;
                iCpuColor = 3'b010;
            end
            if (i == 3) iCpuWrite = 1'b0;
        end
        tick();
        expect_port("f3.done", 1'b0, 19'd0, 3'd0);
        expect_flags("f3.done", 1'b0, 1'b1, 1'b0);
        tick();
        expect_flags("f3.after", 1'b0, 1'b0, 1'b0);

        // 4. rejected rectangles: X overflow, W=0, Y overflow, H=0
        bad_x0 = '{9'd398, 9'd0, 9'd0, 9'd0};
        bad_y0 = '{8'd0, 8'd0, 8'd200, 8'd0};
        bad_w  = '{9'd3, 9'd0, 9'd1, 9'd1};
        bad_h  = '{8'd1, 8'd1, 8'd41, 8'd0};
        for (int i = 0; i < 4; i++) begin
            fill(bad_x0[i], bad_y0[i], bad_w[i], bad_h[i], 3'b001);
            tick();
            iFillStart = 1'b0;
            expect_flags("rej.pulse", 1'b0, 1'b0, 1'b1);
            expect_port("rej.pulse", 1'b0, 19'd0, 3'd0);
            for (int j = 0; j < 2; j++) begin
                tick();
                expect_flags("rej.after", 1'b0, 1'b0, 1'b0);
                expect_port("rej.after", 1'b0, 19'd0, 3'd0);
            end
        end

        // start and abort together in IDLE: abort wins
        fill(9'd0, 8'd0, 9'd3, 8'd2, 3'b100);
        iFillAbort = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            iFillStart = 1'b0;
            iFillAbort = 1'b0;
            expect_flags("st_ab", 1'b0, 1'b0, 1'b0);
            expect_port("st_ab", 1'b0, 19'd0, 3'd0);
        end

        // 5. bottom-right corner pixel
        fill(9'd399, 8'd239, 9'd1, 8'd1, 3'b011);
        tick();
        iFillStart = 1'b0;
        expect_flags("f5.start", 1'b1, 1'b0, 1'b0);
        tick();
        expect_port("f5.px", 1'b1, 19'd95999, 3'b011);
        expect_flags("f5.px", 1'b0, 1'b0, 1'b0);
        tick();
        expect_port("f5.done", 1'b0, 19'd0, 3'd0);
        expect_flags("f5.done", 1'b0, 1'b1, 1'b0);
        tick();
        expect_flags("f5.after", 1'b0, 1'b0, 1'b0);

        // 6a. abort a 10x10 fill after 4 writes, CPU write in the abort cycle still issued
        fill(9'd0, 8'd0, 9'd10, 8'd10, 3'b001);
        tick();
        iFillStart = 1'b0;
        expect_flags("f6.start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_port("f6.px", 1'b1, 19'(i), 3'b001);
            expect_flags("f6.px", 1'b1, 1'b0, 1'b0);
        end
        iFillAbort = 1'b1;
        iCpuWrite  = 1'b1;
        iCpuAddr   = 19'd77;
        iCpuColor  = 3'b110;
        tick();
        iFillAbort = 1'b0;
        iCpuWrite  = 1'b0;
        expect_port("f6.abort", 1'b1, 19'd77, 3'b110);
        expect_flags("f6.abort", 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick();
            expect_port("f6.quiet", 1'b0, 19'd0, 3'd0);
            expect_flags("f6.quiet", 1'b0, 1'b0, 1'b0);
        end

        // 6b. new fill succeeds, then asynchronous reset mid-fill
        fill(9'd5, 8'd1, 9'd10, 8'd10, 3'b010);
        tick();
        iFillStart = 1'b0;
        expect_flags("f6b.start", 1'b1, 1'b0, 1'b0);
        tick();
        expect_port("f6b.px0", 1'b1, 19'd405, 3'b010);
        tick();
        expect_port("f6b.px1", 1'b1, 19'd406, 3'b010);
        expect_flags("f6b.px1", 1'b1, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst.we", 32'(oWriteEnable), 32'd0);
        chk("arst.addr", 32'(oWriteAddr), 32'd0);
        chk("arst.color", 32'(oWriteColor), 32'd0);
        expect_flags("arst", 1'b0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            expect_port("arst.idle", 1'b0, 19'd0, 3'd0);
            expect_flags("arst.idle", 1'b0, 1'b0, 1'b0);
        end
        fill(9'd0, 8'd0, 9'd1, 8'd1, 3'b111);
        tick();
        iFillStart = 1'b0;
        expect_flags("post.start", 1'b1, 1'b0, 1'b0);
        tick();
        expect_port("post.px", 1'b1, 19'd0, 3'b111);
        tick();
        expect_flags("post.done", 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
